ccd_linear_timing_gen: RTL
==========================

CCD_LINEAR_TIMING_GEN -- requirements
Module: ccd_linear_timing_gen

Interface
REQ-001 Parameter LINE_PIXELS, default 2088: pixel periods shifted out per line (TRAN length).
REQ-002 Parameter LOAD_CLKS, default 13: pixel periods in LOAD (f2 held high, rs/cp masked).
REQ-003 Parameter SH_START, default 2; SH_STOP, default 10: sh high for LOAD pixel counts SH_START < n < SH_STOP (7 periods at defaults).
REQ-004 Parameter CNT_W, default 23: width of line_period and pix_idx.
REQ-005 sys_clk  in  1  single clock; all logic on rising edge; no derived or buffered clocks.
REQ-006 sys_rst  in  1  synchronous, active-high reset.
REQ-007 f1_div  in  8  sys_clk cycles per pixel period.
REQ-008 line_period  in  CNT_W  total pixel periods per line.
REQ-009 trig_mode  in  1  0 = free-run, 1 = one line per trig pulse.
REQ-010 trig  in  1  line-start request, one sys_clk pulse; used only when trig_mode=1.
REQ-011 sh, f1, f2, rs, cp  out  1  each  CCD drive signals.
REQ-012 pclk  out  1  pixel-rate level for the ADC (high for the first half of the pixel period).
REQ-013 rs_plus  out  1  unmasked rs phase for the ADC.
REQ-014 os_tvalid  out  1  high for every pixel period of TRAN.
REQ-015 pix_idx  out  CNT_W  pixel index 0..LINE_PIXELS-1 while os_tvalid=1, else 0.
REQ-016 line_start  out  1  one-sys_clk pulse on entry to LOAD.
REQ-017 busy  out  1  high in LOAD, TRAN, WAIT.

Function
REQ-018 Effective divider D = max(4, f1_div with bit0 cleared); D is sampled only when div_cnt wraps.
REQ-019 div_cnt counts 0..D-1 and wraps; pixel tick pt = (div_cnt == D-1).
REQ-020 Registered pclk = 1 when div_cnt < D/2, else 0.
REQ-021 rs_plus = 1 at div_cnt ∈ {0,1}; cp phase = 1 at div_cnt ∈ {2,3}; both registered.
REQ-022 f2 = pclk OR (state==LOAD); f1 = NOT f2; never both high in the same sys_clk cycle.
REQ-023 rs = rs_plus AND (state != LOAD); cp = cp phase AND (state != LOAD).
REQ-024 FSM states: IDLE, LOAD, TRAN, WAIT; advances only on pt.
REQ-025 IDLE: with trig_mode=0, go to LOAD on the next pt; with trig_mode=1, go on the first pt at or after a latched trig.
REQ-026 A trig arriving while busy=1 is dropped; one trig latched in IDLE is held until it is consumed.
REQ-027 On IDLE->LOAD, latch P = max(line_period, LOAD_CLKS+LINE_PIXELS+2); P is held for the whole line.
REQ-028 LOAD lasts LOAD_CLKS pixel periods; sh is registered per REQ-003 and is 0 in every other state.
REQ-029 TRAN lasts LINE_PIXELS periods; os_tvalid and pix_idx update on the pt that enters each pixel.
REQ-030 WAIT lasts P-LOAD_CLKS-LINE_PIXELS-1 periods, then IDLE (1 period); total line = P pixel periods in free-run.
REQ-031 Changes to line_period or trig_mode mid-line take effect at the next IDLE->LOAD transition only.
REQ-032 Counters saturate-free: pix_idx never exceeds LINE_PIXELS-1; the line counter is CNT_W bits and cannot overflow with clamped P.

Reset
REQ-033 While sys_rst=1: div_cnt=0, state=IDLE, trig latch cleared; sh=0, f1=0, f2=1, rs=0, cp=0, pclk=0, rs_plus=0, os_tvalid=0, pix_idx=0, line_start=0, busy=0.
REQ-034 Reset asserted mid-line aborts the line in the next cycle; after release, the first LOAD starts no earlier than the first pt.

Verification
REQ-035 f1_div=16, line_period=3000, trig_mode=0 -> pclk period 16 cycles; line_start spacing 48000 cycles; 2088 os_tvalid pixels per line.
REQ-036 f1_div=7 and f1_div=2 -> effective D=6 and D=4; f1/f2 complementary at every cycle.
REQ-037 line_period=100 -> clamped to 2103; line_start spacing 2103*D cycles.
REQ-038 trig_mode=1, trig pulse in IDLE, second trig mid-TRAN -> exactly one line, then IDLE with busy=0.
REQ-039 LOAD at defaults -> sh high for pixel counts 3..9 (7 periods); rs=cp=0 and f2=1 throughout LOAD.
REQ-040 sys_rst pulsed during TRAN -> next cycle all outputs at REQ-033 values; normal lines resume.

Source files
------------

// File: rtl/ccd_linear_timing_gen.sv
// ccd_linear_timing_gen: linear CCD timing generator with pixel divider, LOAD/TRAN/WAIT line sequencer and registered drive outputs.
module ccd_linear_timing_gen #(
    parameter int LINE_PIXELS = 2088,
    parameter int LOAD_CLKS   = 13,
    parameter int SH_START    = 2,
    parameter int SH_STOP     = 10,
    parameter int CNT_W       = 23
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [7:0]       f1_div,
    input  logic [CNT_W-1:0] line_period,
    input  logic             trig_mode,
    input  logic             trig,
    output logic             sh,
    output logic             f1,
    output logic             f2,
    output logic             rs,
    output logic             cp,
    output logic             pclk,
    output logic             rs_plus,
    output logic             os_tvalid,
    output logic [CNT_W-1:0] pix_idx,
    output logic             line_start,
    output logic             busy
);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, TRAN = 2'd2, WAIT = 2'd3;
    localparam logic [CNT_W-1:0] P_MIN     = CNT_W'(LOAD_CLKS + LINE_PIXELS + 2);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CLKS - 1);
    localparam logic [CNT_W-1:0] TRAN_LAST = CNT_W'(LINE_PIXELS - 1);

    logic [7:0] div_cnt, div_d, div_n, d_n, f1_even, eff_div;
    logic [1:0] state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, p_len, p_n;
    logic trig_lat, trig_n, pt, pend, go, last, pclk_n, rsp_n, cpp_n, load_n;

    always_comb begin
        f1_even = f1_div & 8'hFE;
        eff_div = f1_even < 8'd4 ? 8'd4 : f1_even;
        pt = div_cnt == div_d - 8'd1;
        div_n = pt ? 8'd0 : div_cnt + 8'd1;
        d_n = pt ? eff_div : div_d;
        pend = trig_lat | trig;
        go = pt && state == IDLE && (!trig_mode || pend);
        trig_n = state == IDLE && pend && !go;
        // WAIT runs P-LOAD_CLKS-LINE_PIXELS-1 periods, so its last count is P-P_MIN
        last = (state == LOAD && cnt == LOAD_LAST) || (state == TRAN && cnt == TRAN_LAST) ||
               (state == WAIT && cnt == p_len - P_MIN);
        state_n = go ? LOAD : (pt && state != IDLE && last) ? (state == WAIT ? IDLE : state + 2'd1) : state;
        cnt_n = (go || (pt && last)) ? '0 : (pt && state != IDLE) ? cnt + CNT_W'(1) : cnt;
        p_n = go ? (line_period > P_MIN ? line_period : P_MIN) : p_len;
        pclk_n = div_n < {1'b0, d_n[7:1]};
        rsp_n = div_n < 8'd2;
        cpp_n = div_n[7:1] == 7'd1;
        load_n = state_n == LOAD;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_cnt    <= '0;
            div_d      <= eff_div;
            state      <= IDLE;
            cnt        <= '0;
            p_len      <= P_MIN;
            trig_lat   <= 1'b0;
            sh         <= 1'b0;
            f1         <= 1'b0;
            f2         <= 1'b1;
            rs         <= 1'b0;
            cp         <= 1'b0;
            pclk       <= 1'b0;
            rs_plus    <= 1'b0;
            os_tvalid  <= 1'b0;
            pix_idx    <= '0;
            line_start <= 1'b0;
            busy       <= 1'b0;
        end else begin
            div_cnt    <= div_n;
            div_d      <= d_n;
            state      <= state_n;
            cnt        <= cnt_n;
            p_len      <= p_n;
            trig_lat   <= trig_n;
            sh         <= load_n && cnt_n > CNT_W'(SH_START) && cnt_n < CNT_W'(SH_STOP);
            f1         <= ~(pclk_n | load_n);
            f2         <= pclk_n | load_n;
            rs         <= rsp_n & ~load_n;
            cp         <= cpp_n & ~load_n;
            pclk       <= pclk_n;
            rs_plus    <= rsp_n;
            os_tvalid  <= state_n == TRAN;
            pix_idx    <= state_n == TRAN ? cnt_n : '0;
            line_start <= go;
            busy       <= state_n != IDLE;
        end
    end
endmodule
